// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int PC_STEP    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/imem_fetch_buf.sv
// Two-entry {pc, instr} fetch FIFO. The head lives in dedicated registers so
// the outputs are registered and hold their last value once the buffer empties.
module fetch_buf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr
);

  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d, nxt_pc_q, nxt_pc_d;
  logic [DATA_W-1:0] head_instr_q, head_instr_d, nxt_instr_q, nxt_instr_d;

  always_comb begin
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    nxt_pc_d     = nxt_pc_q;
    nxt_instr_d  = nxt_instr_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = push_pc;
            head_instr_d = push_instr;
            count_d      = 2'd1;
          end else if (count_q == 2'd1) begin
            nxt_pc_d    = push_pc;
            nxt_instr_d = push_instr;
            count_d     = 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_pc_d    = nxt_pc_q;
            head_instr_d = nxt_instr_q;
            count_d      = 2'd1;
          end else if (count_q == 2'd1) begin
            count_d = 2'd0;
          end
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new entry lands behind whatever remains.
          if (count_q == 2'd2) begin
            head_pc_d    = nxt_pc_q;
            head_instr_d = nxt_instr_q;
            nxt_pc_d     = push_pc;
            nxt_instr_d  = push_instr;
          end else begin
            head_pc_d    = push_pc;
            head_instr_d = push_instr;
            count_d      = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      nxt_pc_q     <= '0;
      nxt_instr_q  <= '0;
    end else begin
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      nxt_pc_q     <= nxt_pc_d;
      nxt_instr_q  <= nxt_instr_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_pc    = head_pc_q;
  assign head_instr = head_instr_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction
// memory and streams {pc, instr} to decode through a 2-entry buffer.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic [15:0]       fetch_count
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic [1:0]        buf_count;
  logic              pop, push;

  assign pop  = out_valid & out_ready;
  assign push = (state_q == RUN) & ~redirect_valid & ((buf_count != FULL_CNT) | pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  if (start)    state_d = RUN;
      default:               state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      // Targets are word aligned; the low address bits are dropped.
      pc_d = redirect_pc & ~ADDR_W'(PC_STEP - 1);
    end else if (push) begin
      pc_d          = pc_q + ADDR_W'(PC_STEP);
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      pc_q          <= RESET_PC;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (pc_q),
    .push_instr (imem_instr),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (buf_count),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  assign imem_addr   = pc_q;
  assign busy        = busy_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a queue-based reference model predicts
// delivered {pc, instr} beats and control outputs under directed and random stimulus.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, redirect_valid, out_ready;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr, out_pc;
  logic [31:0] imem_instr, out_instr;
  logic        out_valid, busy;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [7:0]  m_pc;
  bit          m_run;
  int unsigned m_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int drv_tok = 0;
  int mon_tok = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  imem_fetch_ctrl #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .RESET_PC (8'h00),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .fetch_count    (fetch_count)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_pc  = 8'h00;
    m_run = 1'b0;
    m_cnt = 0;
  endfunction

  // Monitor: compares what the DUT presents this cycle and retires accepted beats.
  initial begin
    forever begin
      wait (drv_tok != mon_tok);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
      chk("busy", {31'd0, busy}, {31'd0, m_run});
      chk("fetch_count", {16'd0, fetch_count}, {16'd0, 16'(m_cnt)});
      if (exp_q.size() != 0 && out_ready) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("beat_pc", {24'd0, out_pc}, {24'd0, e.pc});
        chk("beat_instr", out_instr, e.instr);
      end
      mon_tok = drv_tok;
    end
  end

  task automatic cycle(bit st, bit hr, bit rv, logic [7:0] rp, bit rdy);
    @(negedge clk);
    start = st; halt_req = hr; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    drv_tok++;
    wait (mon_tok == drv_tok);
    if (rv) begin
      exp_q.delete();
      m_pc = rp & 8'hFC;
    end else if (m_run && exp_q.size() < 2) begin
      ent_t e;
      e.pc    = m_pc;
      e.instr = mem[m_pc[7:2]];
      exp_q.push_back(e);
      m_pc  = m_pc + 8'd4;
      m_cnt = m_cnt + 1;
    end
    if (m_run && hr) m_run = 1'b0;
    else if (!m_run && st) m_run = 1'b1;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, rdy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00007033; mem[1] = 32'h00100093;
    mem[2] = 32'h00200113; mem[3] = 32'h00308193;

    start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_pc", {24'd0, out_pc}, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    rst_n = 1'b1;

    // Basic streaming from reset
    idle(2, 1);
    cycle(1, 0, 0, 8'h00, 1);
    idle(5, 1);
    cycle(0, 1, 0, 8'h00, 1);
    idle(4, 1);

    // Back-pressure: buffer fills, PC parks, then drains in order
    cycle(0, 0, 1, 8'h00, 1);
    cycle(1, 0, 0, 8'h00, 0);
    idle(5, 0);
    idle(5, 1);

    // Redirect on a full buffer to an unaligned target
    idle(3, 0);
    cycle(0, 0, 1, 8'h2B, 0);
    idle(1, 0);
    idle(4, 1);

    // Halt mid-stream, drain, resume
    cycle(0, 1, 0, 8'h00, 1);
    idle(4, 1);
    cycle(1, 0, 0, 8'h00, 1);
    idle(4, 1);

    // Halt and redirect together
    cycle(0, 1, 1, 8'h41, 1);
    idle(2, 1);
    cycle(1, 0, 0, 8'h00, 1);
    idle(3, 1);

    // PC wrap
    cycle(0, 0, 1, 8'hF4, 1);
    idle(6, 1);

    // Asynchronous reset with a full buffer
    idle(4, 0);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 0; halt_req = 0; redirect_valid = 0; out_ready = 0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_fetch_count", {16'd0, fetch_count}, 32'd0);
    chk("async_imem_addr", {24'd0, imem_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1);

    // Randomized traffic
    cycle(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
